booth_mul_seq: RTL and testbench
================================

Name: booth_mul_seq

Overview:
- Parametrised, multi-cycle, shift-add radix-2 Booth multiplier with a start/done handshake.
- Successor to the team's 6x6 combinational Booth multiplier: generic operand width and a per-operation signed/unsigned mode.
- Keeps the existing truncated result plus ov-flag output convention, so existing {ov, m} checks carry over.
- Sits in the datapath as a low-area multiplier; one operation in flight at a time.

Parameters:
- WIDTH, 6, operand width in bits (minimum 2).
- PW, 2*WIDTH-1, result width of m (derived; do not override).

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE or DONE.
- sgn  input  1  1 = a/b two's complement; 0 = unsigned. Captured with start.
- a  input  WIDTH  multiplicand, captured with start.
- b  input  WIDTH  multiplier, captured with start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; result valid from this cycle.
- m  output  PW  low PW bits of the product; held until the next accepted start.
- ov  output  1  product does not fit in m (see arithmetic); held with m.

Behaviour:
- Reset, when rst=1 at a clock edge: state=IDLE, busy=0, done=0, m=0, ov=0, and all internal registers cleared. Reset overrides everything, including mid-RUN; no result is produced for an aborted operation.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> capture operands, go to RUN.
  - RUN: lasts exactly WIDTH+1 cycles, then go to DONE.
  - DONE: lasts 1 cycle with done=1. start=1 -> capture, go to RUN; otherwise go to IDLE.
- Operand capture: a and b are extended to WIDTH+1 bits, sign-extended if sgn=1, zero-extended if sgn=0.
  - Accumulator P: 2*(WIDTH+1)+1 bits = {hi, multiplier, q(-1)=0}; hi initialised to 0.
- Each RUN cycle examines the pair {q0, q(-1)}:
  - 01: hi += A
  - 10: hi -= A
  - 00 / 11: no add
  - then arithmetic-shift P right by 1.
- Latency: start sampled at edge N -> done=1 during cycle N+WIDTH+2. Throughput: one result per WIDTH+2 cycles with back-to-back starts.
- m and ov update only on the edge entering DONE; they are stable in IDLE and RUN.
- Arithmetic: full product F is 2*WIDTH bits; m = F[PW-1:0].
  - sgn=0: ov = F[2*WIDTH-1], so {ov, m} equals the exact unsigned product.
  - sgn=1: ov=1 iff F lies outside the signed range of PW bits. The only case is a = b = -2^(WIDTH-1).
- start=1 while busy is ignored: no effect on operands, state or the current result; no error flag.
- a, b and sgn may change freely after capture.

Optional Feature:
- Macro: BOOTH_MUL_SEQ_RADIX4_EN.
- Defined:
  - Radix-4 modified Booth recoding on the (WIDTH+1)-bit multiplier, sign-extended to even length.
  - Per cycle: examine 3 bits, add 0, ±A or ±2A, shift by 2.
  - RUN lasts ceil((WIDTH+1)/2) cycles; latency = ceil((WIDTH+1)/2)+1 after the start edge.
  - m and ov results identical to radix-2.
- Undefined: radix-2 as above.

Test Plan:
- WIDTH=6, sgn=1, a=5, b=-3 (6'h3D) -> done exactly 8 cycles after the start edge; m=11'h7F1 (-15), ov=0.
- sgn=1, a=b=-32 -> m=11'h400, ov=1. sgn=1, a=-32, b=31 -> m=11'h420 (-992), ov=0.
- sgn=0, a=b=63 -> {ov,m}=12'hF81 (ov=1, m=11'h781). sgn=0, a=b=0 -> m=0, ov=0.
- start=1 held every cycle from a=7, b=9 (sgn=0) while operands change each cycle -> first result m=63, then back-to-back operations every 8 cycles; mid-RUN changes ignored.
- rst=1 in the 3rd RUN cycle -> next edge busy=0, done=0, m=0, ov=0; no done pulse follows; a new start after reset works normally.
- Exhaustive: all 64x64 operand pairs x both sgn values compared against the reference product. Run with and without BOOTH_MUL_SEQ_RADIX4_EN; radix-4 latency is 5 cycles.

Source files
------------

// File: rtl/booth_mul_seq.sv
// Sequential Booth multiplier with start/done handshake, truncated result plus overflow flag.
// Define BOOTH_MUL_SEQ_RADIX4_EN for radix-4 modified Booth recoding (fewer RUN cycles, same results).
module booth_mul_seq #(
    parameter int WIDTH = 6,
    parameter int PW    = 2*WIDTH-1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [PW-1:0]    m,
    output logic             ov
);

    localparam int XW = WIDTH + 1;
    // Two guard bits on the high half absorb the +/-2A partial products.
    localparam int HW = WIDTH + 3;
`ifdef BOOTH_MUL_SEQ_RADIX4_EN
    localparam int ML    = XW + (XW % 2);
    localparam int STEPS = ML / 2;
`else
    localparam int ML    = XW;
    localparam int STEPS = XW;
`endif
    localparam int PLEN = HW + ML + 1;
    localparam int CW   = $clog2(STEPS) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PLEN-1:0]   p_q, p_d;
    logic [HW-1:0]     a_q, a_d;
    logic              sgn_q, sgn_d;
    logic [PW-1:0]     m_q, m_d;
    logic              ov_q, ov_d;

    logic              accept;
    logic              last_step;
    logic              a_sx, b_sx;
    logic [HW-1:0]     a_ext;
    logic [ML-1:0]     b_ext;
    logic [HW-1:0]     hi, hi_sum;
    logic signed [PLEN-1:0] p_pre;
    logic [PLEN-1:0]   p_step;
    logic [2*WIDTH-1:0] f;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_step) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
        m    = m_q;
        ov   = ov_q;
    end

    always_comb begin
        a_sx  = sgn & a[WIDTH-1];
        b_sx  = sgn & b[WIDTH-1];
        a_ext = {{(HW-WIDTH){a_sx}}, a};
        b_ext = {{(ML-WIDTH){b_sx}}, b};
    end

    always_comb begin
        hi     = p_q[PLEN-1 -: HW];
        hi_sum = hi;
`ifdef BOOTH_MUL_SEQ_RADIX4_EN
        case (p_q[2:0])
            3'b001, 3'b010: hi_sum = hi + a_q;
            3'b011:         hi_sum = hi + (a_q << 1);
            3'b100:         hi_sum = hi - (a_q << 1);
            3'b101, 3'b110: hi_sum = hi - a_q;
            default:        hi_sum = hi;
        endcase
        p_pre  = {hi_sum, p_q[PLEN-HW-1:0]};
        p_step = p_pre >>> 2;
`else
        case (p_q[1:0])
            2'b01:   hi_sum = hi + a_q;
            2'b10:   hi_sum = hi - a_q;
            default: hi_sum = hi;
        endcase
        p_pre  = {hi_sum, p_q[PLEN-HW-1:0]};
        p_step = p_pre >>> 1;
`endif
        f = p_step[2*WIDTH:1];
    end

    always_comb begin
        accept    = start && (state_q != S_RUN);
        last_step = (state_q == S_RUN) && (cnt_q == '0);
        p_d   = p_q;
        cnt_d = cnt_q;
        a_d   = a_q;
        sgn_d = sgn_q;
        m_d   = m_q;
        ov_d  = ov_q;
        if (accept) begin
            a_d   = a_ext;
            p_d   = {{HW{1'b0}}, b_ext, 1'b0};
            cnt_d = CW'(STEPS-1);
            sgn_d = sgn;
        end else if (state_q == S_RUN) begin
            p_d   = p_step;
            cnt_d = cnt_q - CW'(1);
            if (last_step) begin
                cnt_d = '0;
                m_d   = f[PW-1:0];
                // Signed: the 2W-bit product fits in PW bits only if its top two bits agree.
                ov_d  = sgn_q ? (f[2*WIDTH-1] != f[2*WIDTH-2]) : f[2*WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q   <= '0;
            cnt_q <= '0;
            a_q   <= '0;
            sgn_q <= 1'b0;
            m_q   <= '0;
            ov_q  <= 1'b0;
        end else begin
            p_q   <= p_d;
            cnt_q <= cnt_d;
            a_q   <= a_d;
            sgn_q <= sgn_d;
            m_q   <= m_d;
            ov_q  <= ov_d;
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: cycle-level behavioural model plus directed literal checks.
`timescale 1ns/1ps
module tb_booth_mul_seq;

    localparam int W  = 6;
    localparam int PW = 2*W-1;
`ifdef BOOTH_MUL_SEQ_RADIX4_EN
    localparam int LAT = (W+2)/2 + 1;
`else
    localparam int LAT = W + 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          sgn = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy, done, ov;
    logic [PW-1:0] m;

    int tests = 0;
    int fails = 0;
    int prints = 0;

    booth_mul_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .sgn(sgn), .a(a), .b(b),
        .busy(busy), .done(done), .m(m), .ov(ov)
    );

    always #5 clk = ~clk;

    function automatic logic [PW:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
        longint px, py, f;
        logic [63:0] fu;
        logic ov_r;
        if (s) begin
            px = $signed(x);
            py = $signed(y);
            f = px * py;
            ov_r = (f > (2**(PW-1)) - 1) || (f < -(2**(PW-1)));
        end else begin
            px = longint'(x);
            py = longint'(y);
            f = px * py;
            ov_r = (f >= 2**PW);
        end
        fu = f;
        return {ov_r, fu[PW-1:0]};
    endfunction

    // Model: an accepted start yields a done pulse LAT-1 edges later; busy while the count runs.
    int            remain = 0;
    logic          exp_done = 1'b0;
    logic [PW-1:0] exp_m = '0;
    logic          exp_ov = 1'b0;
    logic [PW:0]   pend = '0;
    logic          mdl_ok = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            remain   <= 0;
            exp_done <= 1'b0;
            exp_m    <= '0;
            exp_ov   <= 1'b0;
            mdl_ok   <= 1'b1;
        end else begin
            if (remain == 1) begin
                exp_done <= 1'b1;
                {exp_ov, exp_m} <= pend;
            end else begin
                exp_done <= 1'b0;
            end
            if (start && remain == 0) begin
                pend   <= ref_prod(a, b, sgn);
                remain <= LAT - 1;
            end else if (remain > 0) begin
                remain <= remain - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_ok) begin
            tests++;
            if ({busy, done, m, ov} !== {(remain != 0), exp_done, exp_m, exp_ov}) begin
                fails++;
                if (prints < 20) begin
                    prints++;
                    $display("FAIL model t=%0t busy/done/m/ov got %b/%b/%h/%b want %b/%b/%h/%b",
                             $time, busy, done, m, ov, (remain != 0), exp_done, exp_m, exp_ov);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic run_lit(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic s, input int em, input int eov);
        int k;
        @(negedge clk);
        a = x; b = y; sgn = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_lat"}, k, LAT);
        chk({name, "_m"}, int'(m), em);
        chk({name, "_ov"}, int'(ov), eov);
    endtask

    initial begin
        int k;
        int seen;
        #2_000_000;
        $display("FAIL watchdog expired");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int seen;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_m", int'(m), 0);
        chk("rst_ov", int'(ov), 0);
        rst = 1'b0;

        run_lit("s_5x-3", 6'd5, 6'h3D, 1'b1, 'h7F1, 0);
        run_lit("u_63x63", 6'd63, 6'd63, 1'b0, 'h781, 1);
        run_lit("u_0x0", 6'd0, 6'd0, 1'b0, 0, 0);
        run_lit("s_-32x-32", 6'h20, 6'h20, 1'b1, 'h400, 1);
        run_lit("s_-32x31", 6'h20, 6'd31, 1'b1, 'h420, 0);

        // Reset during the third RUN cycle aborts the operation and clears the result.
        @(negedge clk);
        a = 6'd5; b = 6'd3; sgn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_m", int'(m), 0);
        chk("abort_ov", int'(ov), 0);
        rst = 1'b0;
        seen = 0;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("abort_no_done", seen, 0);
        run_lit("post_rst_3x4", 6'd3, 6'd4, 1'b0, 12, 0);

        // start held high with operands churning every cycle.
        @(negedge clk);
        a = 6'd7; b = 6'd9; sgn = 1'b0; start = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            a = 6'($urandom_range(0, 63));
            b = 6'($urandom_range(0, 63));
            sgn = 1'($urandom_range(0, 1));
        end while (!done && k < 20);
        chk("held_first_lat", k, LAT);
        chk("held_first_m", int'(m), 63);
        chk("held_first_ov", int'(ov), 0);
        for (int r = 0; r < 3; r++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
                a = 6'($urandom_range(0, 63));
                b = 6'($urandom_range(0, 63));
                sgn = 1'($urandom_range(0, 1));
            end while (!done && k < 20);
            chk("held_period", k, LAT);
        end
        start = 1'b0;
        repeat (LAT + 1) @(negedge clk);

        // Exhaustive sweep, back-to-back; result values are checked by the model process.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 64; i++) begin
                for (int j = 0; j < 64; j++) begin
                    a = 6'(i); b = 6'(j); sgn = 1'(s); start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                    k = 1;
                    while (!done && k < 20) begin
                        @(negedge clk);
                        k++;
                    end
                    tests++;
                    if (!done) begin
                        fails++;
                        $display("FAIL sweep_timeout a=%0d b=%0d sgn=%0d got no done want done", i, j, s);
                    end
                end
            end
        end
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
